logic_reduce_unit: RTL and testbench



---
 rtl/logic_reduce_unit.sv | 136 +++++++++++++
 tb/tb_logic_reduce_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_unit.sv
// Streaming frame reducer: folds every lane of every beat in a frame with a
// selectable bitwise operator and returns one result word plus a beat count.
module logic_reduce_unit #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             op,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_sat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NAND folds as AND; the inversion is applied once when the result is registered.
    function automatic logic [WIDTH-1:0] f_combine(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (sel)
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_sat;

    logic             w_first;
    logic             w_accept;
    logic [1:0]       w_op_sel;
    logic [WIDTH-1:0] w_lr;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;
    logic [WIDTH-1:0] w_out_data_next;

    assign w_first  = (r_state == S_IDLE);
    assign in_ready = (r_state != S_HOLD);
    assign w_accept = in_valid && in_ready;

    // The op input only matters on the first beat; later beats use the latched copy.
    assign w_op_sel = w_first ? op : r_op;

    always_comb begin
        w_lr = in_data[0 +: WIDTH];
        for (int i = 1; i < LANES; i++) begin
            w_lr = f_combine(w_op_sel, w_lr, in_data[i*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        w_acc_next      = w_first ? w_lr : f_combine(r_op, r_acc, w_lr);
        w_cnt_next      = w_first ? CNT_W'(1) : f_sat_inc(r_cnt);
        w_sat_next      = w_first ? 1'b0 : (r_sat || (r_cnt == CNT_MAX));
        w_out_data_next = (w_op_sel == OP_NAND) ? ~w_acc_next : w_acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_AND;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_op <= op;
                        end
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_sat <= w_sat_next;
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_data  <= w_out_data_next;
                            r_out_count <= w_cnt_next;
                            r_out_sat   <= w_sat_next;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit: a default-size instance and a CNT_W=2
// instance share the same stimulus so counter saturation is visible on one of them.
module tb_logic_reduce_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a;
    logic [7:0]  out_data_a, out_count_a;
    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [7:0]  out_data_b;
    logic [1:0]  out_count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic_reduce_unit #(.WIDTH(8), .LANES(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_count(out_count_a),
        .out_sat(out_sat_a)
    );

    logic_reduce_unit #(.WIDTH(8), .LANES(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_count(out_count_b),
        .out_sat(out_sat_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("consume_valid_drop", {31'd0, out_valid_a}, 32'd0);
        check("consume_ready_back", {31'd0, in_ready_a}, 32'd1);
    endtask

    task automatic beat(input logic [1:0] o, input logic [31:0] d, input logic l);
        op       = o;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        check("beat_in_ready", {31'd0, in_ready_a}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [7:0] held_data;

    initial begin
        // lanes listed lane3..lane0 in the packed constant
        vecs[0] = '{2'b00, 32'hFF3CF0FF, 8'h30};
        vecs[1] = '{2'b01, 32'h80040201, 8'h87};
        vecs[2] = '{2'b10, 32'h01F00FFF, 8'h01};
        vecs[3] = '{2'b11, 32'hFFFFFFFF, 8'h00};
        vecs[4] = '{2'b11, 32'hFFFF7FFF, 8'h80};
        vecs[5] = '{2'b01, 32'h00000000, 8'h00};
        vecs[6] = '{2'b10, 32'h000055AA, 8'hFF};

        rst = 1'b1; op = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out_data",  {24'd0, out_data_a}, 32'd0);
        check("rst_out_count", {24'd0, out_count_a}, 32'd0);
        check("rst_out_sat",   {31'd0, out_sat_a}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready_a}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            beat(vecs[i].op, vecs[i].data, 1'b1);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid_a}, 32'd1);
            check($sformatf("vec%0d_data", i), {24'd0, out_data_a}, {24'd0, vecs[i].exp});
            check($sformatf("vec%0d_count", i), {24'd0, out_count_a}, 32'd1);
            check($sformatf("vec%0d_sat", i), {31'd0, out_sat_a}, 32'd0);
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready_a}, 32'd0);
            consume();
        end

        // XOR frame with an idle gap in the middle
        beat(2'b10, 32'h08040201, 1'b0);
        step();
        check("xor_gap_no_valid", {31'd0, out_valid_a}, 32'd0);
        beat(2'b10, 32'h00000010, 1'b0);
        beat(2'b10, 32'h80000000, 1'b1);
        check("xor_valid", {31'd0, out_valid_a}, 32'd1);
        check("xor_data",  {24'd0, out_data_a}, 32'h9F);
        check("xor_count", {24'd0, out_count_a}, 32'd3);
        consume();

        // op on the second beat must be ignored
        beat(2'b11, 32'hFFFFFFFF, 1'b0);
        beat(2'b01, 32'hFFFFFFFF, 1'b1);
        check("nand_latched_data",  {24'd0, out_data_a}, 32'h00);
        check("nand_latched_count", {24'd0, out_count_a}, 32'd2);
        consume();

        // Backpressure with a waiting sender
        beat(2'b01, 32'h00000055, 1'b1);
        held_data = 8'h55;
        op = 2'b01; in_data = 32'h00000002; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp%0d_in_ready", k), {31'd0, in_ready_a}, 32'd0);
            check($sformatf("bp%0d_valid", k), {31'd0, out_valid_a}, 32'd1);
            check($sformatf("bp%0d_data", k), {24'd0, out_data_a}, {24'd0, held_data});
            check($sformatf("bp%0d_count", k), {24'd0, out_count_a}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid_a}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready_a}, 32'd1);
        check("bp_data_after_consume", {24'd0, out_data_a}, {24'd0, held_data});
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_held_beat_valid", {31'd0, out_valid_a}, 32'd1);
        check("bp_held_beat_data", {24'd0, out_data_a}, 32'h02);
        consume();

        // Counter saturation: 5 beats, CNT_W=8 counts 5, CNT_W=2 pins at 3
        for (int k = 0; k < 5; k++) begin
            beat(2'b01, 32'h00000001, (k == 4));
        end
        check("sat_a_data",  {24'd0, out_data_a}, 32'h01);
        check("sat_a_count", {24'd0, out_count_a}, 32'd5);
        check("sat_a_sat",   {31'd0, out_sat_a}, 32'd0);
        check("sat_b_valid", {31'd0, out_valid_b}, 32'd1);
        check("sat_b_data",  {24'd0, out_data_b}, 32'h01);
        check("sat_b_count", {30'd0, out_count_b}, 32'd3);
        check("sat_b_sat",   {31'd0, out_sat_b}, 32'd1);
        consume();

        // Reset mid-frame discards the partial frame
        beat(2'b10, 32'h000000F0, 1'b0);
        beat(2'b10, 32'h0000000F, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid_a}, 32'd0);
        check("midrst_count", {24'd0, out_count_a}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
        step();
        check("midrst_no_result", {31'd0, out_valid_a}, 32'd0);
        beat(2'b01, 32'h00000001, 1'b1);
        check("postrst_valid", {31'd0, out_valid_a}, 32'd1);
        check("postrst_data",  {24'd0, out_data_a}, 32'h01);
        check("postrst_count", {24'd0, out_count_a}, 32'd1);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
        $fatal(1, "watchdog");
    end

endmodule
